// File: rtl/pcie_dma_pkg.sv
// Shared TLP fmt/type codes, RX engine state codes, the RX register struct and the
// byte-count / address-offset helpers used by the PIO RX engine.
package pcie_dma_pkg;

  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] MRD64 = 7'h20;
  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;
  localparam logic [6:0] CPLD  = 7'h4A;
  localparam logic [6:0] CPL   = 7'h0A;

  localparam logic [3:0] ST_RST      = 4'd0;
  localparam logic [3:0] ST_RD32_QW1 = 4'd1;
  localparam logic [3:0] ST_RD64_QW1 = 4'd2;
  localparam logic [3:0] ST_WR32_QW1 = 4'd3;
  localparam logic [3:0] ST_WR64_QW1 = 4'd4;
  localparam logic [3:0] ST_WR64_QW2 = 4'd5;
  localparam logic [3:0] ST_DMA_REQ  = 4'd6;
  localparam logic [3:0] ST_WAIT_CPL = 4'd7;
  localparam logic [3:0] ST_DISCARD  = 4'd8;

  typedef struct packed {
    logic [3:0]  state;
    logic        tready;
    logic        req_compl;
    logic        req_compl_wd;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
    logic [9:0]  bytes;
    logic        dma_valid;
    logic        dma_write;
    logic [31:0] data;
  } rx_reg_t;

  // len==1 uses the first-BE span; longer requests are len*4 modulo 1024.
  function automatic logic [9:0] be2bytes(input logic [3:0] be, input logic [9:0] len);
    logic [9:0] bytes;
    if (len != 10'd1) begin
      bytes = {len[7:0], 2'b00};
    end else begin
      casez (be)
        4'b1??1:                   bytes = 10'd4;
        4'b01?1, 4'b1?10:          bytes = 10'd3;
        4'b0011, 4'b0110, 4'b1100: bytes = 10'd2;
        default:                   bytes = 10'd1;
      endcase
    end
    return bytes;
  endfunction

  function automatic logic [1:0] be2offset(input logic [3:0] be);
    logic [1:0] off;
    casez (be)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/pcie_io_rx_engine_if.sv
// RX AXI-Stream, completion-request and DMA-request signals of the PIO RX engine.
interface pcie_io_rx_engine_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
  logic                    i_m_axis_rx_tvalid;
  logic [C_DATA_WIDTH-1:0] i_m_axis_rx_tdata;
  logic [KEEP_WIDTH-1:0]   i_m_axis_rx_tkeep;
  logic                    i_m_axis_rx_tlast;
  logic                    o_m_axis_rx_tready;
  logic                    o_req_compl;
  logic                    o_req_compl_wd;
  logic                    i_compl_done;
  logic [2:0]              o_req_tc;
  logic                    o_req_td;
  logic                    o_req_ep;
  logic [1:0]              o_req_attr;
  logic [9:0]              o_req_len;
  logic [15:0]             o_req_rid;
  logic [7:0]              o_req_tag;
  logic [7:0]              o_req_be;
  logic [12:0]             o_req_addr;
  logic [9:0]              o_req_bytes;
  logic                    o_dma_req_valid;
  logic                    i_dma_req_ready;
  logic                    o_dma_req_write;
  logic [12:0]             o_dma_req_addr;
  logic [9:0]              o_dma_req_bytes;
  logic [63:0]             o_dma_req_data;
  logic [7:0]              o_dma_req_strob;

  modport slave (
    input  i_m_axis_rx_tvalid, i_m_axis_rx_tdata, i_m_axis_rx_tkeep, i_m_axis_rx_tlast,
    input  i_compl_done, i_dma_req_ready,
    output o_m_axis_rx_tready, o_req_compl, o_req_compl_wd, o_req_tc, o_req_td, o_req_ep,
    output o_req_attr, o_req_len, o_req_rid, o_req_tag, o_req_be, o_req_addr, o_req_bytes,
    output o_dma_req_valid, o_dma_req_write, o_dma_req_addr, o_dma_req_bytes,
    output o_dma_req_data, o_dma_req_strob
  );

  modport master (
    output i_m_axis_rx_tvalid, i_m_axis_rx_tdata, i_m_axis_rx_tkeep, i_m_axis_rx_tlast,
    output i_compl_done, i_dma_req_ready,
    input  o_m_axis_rx_tready, o_req_compl, o_req_compl_wd, o_req_tc, o_req_td, o_req_ep,
    input  o_req_attr, o_req_len, o_req_rid, o_req_tag, o_req_be, o_req_addr, o_req_bytes,
    input  o_dma_req_valid, o_dma_req_write, o_dma_req_addr, o_dma_req_bytes,
    input  o_dma_req_data, o_dma_req_strob
  );
endinterface

// File: rtl/pcie_io_rx_engine.sv
// PIO RX engine: parses 64-bit request TLPs, issues one DMA request per TLP and, for reads,
// holds the completion request until the TX engine reports completion.
module pcie_io_rx_engine
  import pcie_dma_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  pcie_io_rx_engine_if.slave bus
);

  rx_reg_t     cur_r;
  rx_reg_t     nxt_s;
  logic        beat_s;
  logic        last_s;
  logic [63:0] q_s;
  logic [6:0]  ft_s;
  logic        known_s;
  logic        unused_s;

  assign q_s      = bus.i_m_axis_rx_tdata;
  assign last_s   = bus.i_m_axis_rx_tlast;
  assign beat_s   = bus.i_m_axis_rx_tvalid & cur_r.tready;
  assign ft_s     = q_s[30:24];
  assign known_s  = (ft_s == MRD32) || (ft_s == MRD64) || (ft_s == MWR32) || (ft_s == MWR64);
  assign unused_s = ^bus.i_m_axis_rx_tkeep;

  // Next-state and next-output computation over the whole register struct.
  always_comb begin
    nxt_s = cur_r;
    case (cur_r.state)
      ST_RST: begin
        if (beat_s) begin
          if (known_s) begin
            nxt_s.tc        = q_s[22:20];
            nxt_s.td        = q_s[15];
            nxt_s.ep        = q_s[14];
            nxt_s.attr      = q_s[13:12];
            nxt_s.len       = q_s[9:0];
            nxt_s.rid       = q_s[63:48];
            nxt_s.tag       = q_s[47:40];
            nxt_s.be        = q_s[39:32];
            nxt_s.bytes     = be2bytes(q_s[35:32], q_s[9:0]);
            nxt_s.dma_write = (ft_s == MWR32) || (ft_s == MWR64);
            nxt_s.data      = 32'h0;
          end else begin
            nxt_s.data = cur_r.data;
          end
          // A header beat carrying tlast ends the TLP with no request, whatever its type.
          if (last_s) begin
            nxt_s.state = ST_RST;
          end else begin
            case (ft_s)
              MRD32:   nxt_s.state = ST_RD32_QW1;
              MRD64:   nxt_s.state = ST_RD64_QW1;
              MWR32:   nxt_s.state = ST_WR32_QW1;
              MWR64:   nxt_s.state = ST_WR64_QW1;
              default: nxt_s.state = ST_DISCARD;
            endcase
          end
        end else begin
          nxt_s.state = ST_RST;
        end
      end
      ST_RD32_QW1, ST_WR32_QW1: begin
        if (beat_s) begin
          nxt_s.addr      = {q_s[12:2], be2offset(cur_r.be[3:0])};
          nxt_s.data      = (cur_r.state == ST_WR32_QW1) ? q_s[63:32] : 32'h0;
          nxt_s.dma_valid = 1'b1;
          nxt_s.state     = ST_DMA_REQ;
        end else begin
          nxt_s.state = cur_r.state;
        end
      end
      ST_RD64_QW1, ST_WR64_QW1: begin
        if (beat_s) begin
          nxt_s.addr = {q_s[44:34], be2offset(cur_r.be[3:0])};
          if (cur_r.state == ST_WR64_QW1) begin
            nxt_s.state = ST_WR64_QW2;
          end else begin
            nxt_s.dma_valid = 1'b1;
            nxt_s.state     = ST_DMA_REQ;
          end
        end else begin
          nxt_s.state = cur_r.state;
        end
      end
      ST_WR64_QW2: begin
        if (beat_s) begin
          nxt_s.data      = q_s[31:0];
          nxt_s.dma_valid = 1'b1;
          nxt_s.state     = ST_DMA_REQ;
        end else begin
          nxt_s.state = ST_WR64_QW2;
        end
      end
      ST_DMA_REQ: begin
        if (bus.i_dma_req_ready) begin
          nxt_s.dma_valid = 1'b0;
          if (cur_r.dma_write) begin
            nxt_s.state = ST_RST;
          end else begin
            nxt_s.req_compl    = 1'b1;
            nxt_s.req_compl_wd = 1'b1;
            nxt_s.state        = ST_WAIT_CPL;
          end
        end else begin
          nxt_s.dma_valid = 1'b1;
        end
      end
      ST_WAIT_CPL: begin
        if (bus.i_compl_done) begin
          nxt_s.req_compl    = 1'b0;
          nxt_s.req_compl_wd = 1'b0;
          nxt_s.state        = ST_RST;
        end else begin
          nxt_s.state = ST_WAIT_CPL;
        end
      end
      ST_DISCARD: begin
        if (beat_s && last_s) begin
          nxt_s.state = ST_RST;
        end else begin
          nxt_s.state = ST_DISCARD;
        end
      end
      default: begin
        nxt_s = '0;
      end
    endcase
    // RX is stalled from the request until the engine is back in RST.
    nxt_s.tready = (nxt_s.state != ST_DMA_REQ) && (nxt_s.state != ST_WAIT_CPL);
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_r <= '0;
    end else begin
      cur_r <= nxt_s;
    end
  end

  assign bus.o_m_axis_rx_tready = cur_r.tready;
  assign bus.o_req_compl        = cur_r.req_compl;
  assign bus.o_req_compl_wd     = cur_r.req_compl_wd;
  assign bus.o_req_tc           = cur_r.tc;
  assign bus.o_req_td           = cur_r.td;
  assign bus.o_req_ep           = cur_r.ep;
  assign bus.o_req_attr         = cur_r.attr;
  assign bus.o_req_len          = cur_r.len;
  assign bus.o_req_rid          = cur_r.rid;
  assign bus.o_req_tag          = cur_r.tag;
  assign bus.o_req_be           = cur_r.be;
  assign bus.o_req_addr         = cur_r.addr;
  assign bus.o_req_bytes        = cur_r.bytes;
  assign bus.o_dma_req_valid    = cur_r.dma_valid;
  assign bus.o_dma_req_write    = cur_r.dma_write;
  assign bus.o_dma_req_addr     = {cur_r.addr[12:2], 2'b00};
  assign bus.o_dma_req_bytes    = cur_r.bytes;
  assign bus.o_dma_req_data     = {32'h0, cur_r.data};
  assign bus.o_dma_req_strob    = {4'h0, cur_r.be[3:0]};

endmodule
